// File: rtl/hwag_sched_if.sv
// rtl/hwag_sched_if.sv - Run control, angle, config and output bundle for the HWAG channel scheduler
interface hwag_sched_if #(
   parameter int CH_NUM   = 8,
   parameter int ANGLE_W  = 24,
   parameter int CH_IDX_W = 3
) ();
   logic                ena;
   logic [ANGLE_W-1:0]  angle;
   logic                cfg_we;
   logic [CH_IDX_W:0]   cfg_addr;
   logic [ANGLE_W-1:0]  cfg_data;
   logic [CH_NUM-1:0]   ch_out;
   logic [CH_IDX_W-1:0] scan_idx;
   logic [CH_NUM-1:0]   evt_irq;

   modport master (
      output ena, angle, cfg_we, cfg_addr, cfg_data,
      input  ch_out, scan_idx, evt_irq
   );

   modport slave (
      input  ena, angle, cfg_we, cfg_addr, cfg_data,
      output ch_out, scan_idx, evt_irq
   );
endinterface

// File: rtl/hwag_channel_scheduler.sv
// rtl/hwag_channel_scheduler.sv - Round-robin angle comparator driving CH_NUM set/reset outputs
// Optional per-channel event pulses are built when HWAG_SCHED_EVT_IRQ_EN is defined.
module hwag_channel_scheduler #(
   parameter int CH_NUM   = 8,
   parameter int ANGLE_W  = 24,
   parameter int CH_IDX_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   hwag_sched_if.slave  bus
);
   localparam logic [0:0]          S_IDLE      = 1'b0;
   localparam logic [0:0]          S_SCAN      = 1'b1;
   localparam logic [CH_IDX_W:0]   LP_CH_NUM   = (CH_IDX_W+1)'(CH_NUM);
   localparam logic [CH_IDX_W-1:0] LP_LAST_IDX = CH_IDX_W'(CH_NUM - 1);

   logic [0:0]          r_state;
   logic [ANGLE_W-1:0]  r_sh_set  [CH_NUM];
   logic [ANGLE_W-1:0]  r_sh_rst  [CH_NUM];
   logic [ANGLE_W-1:0]  r_act_set [CH_NUM];
   logic [ANGLE_W-1:0]  r_act_rst [CH_NUM];
   logic [ANGLE_W-1:0]  r_last    [CH_NUM];
   logic [ANGLE_W-1:0]  r_prev_angle;
   logic [CH_IDX_W-1:0] r_scan_idx;
   logic [CH_NUM-1:0]   r_ch_out;

   logic [ANGLE_W-1:0]  w_sh_set_nxt [CH_NUM];
   logic [ANGLE_W-1:0]  w_sh_rst_nxt [CH_NUM];
   logic [CH_IDX_W-1:0] w_wr_ch;
   logic                w_wr_ok;
   logic                w_scan_run;
   logic                w_wrap;
   logic                w_cross_set;
   logic                w_cross_rst;
   logic                w_next_bit;

   // Target T is crossed when it lies in (L, A], taking an angle wrap into account.
   function automatic logic f_cross(input logic [ANGLE_W-1:0] t,
                                    input logic [ANGLE_W-1:0] l,
                                    input logic [ANGLE_W-1:0] a);
      if (a > l)      return (t > l) && (t <= a);
      else if (a < l) return (t > l) || (t <= a);
      else            return 1'b0;
   endfunction

   assign w_wr_ch    = bus.cfg_addr[CH_IDX_W:1];
   assign w_wr_ok    = bus.cfg_we && ({1'b0, w_wr_ch} < LP_CH_NUM);
   assign w_scan_run = bus.ena && (r_state == S_SCAN);
   assign w_wrap     = bus.angle < r_prev_angle;

   // Shadow values including this cycle's write, so a write coinciding with a commit is taken.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         w_sh_set_nxt[i] = r_sh_set[i];
         w_sh_rst_nxt[i] = r_sh_rst[i];
      end
      if (w_wr_ok) begin
         if (bus.cfg_addr[0]) w_sh_rst_nxt[w_wr_ch] = bus.cfg_data;
         else                 w_sh_set_nxt[w_wr_ch] = bus.cfg_data;
      end
   end

   assign w_cross_rst = f_cross(r_act_rst[r_scan_idx], r_last[r_scan_idx], bus.angle);
   assign w_cross_set = f_cross(r_act_set[r_scan_idx], r_last[r_scan_idx], bus.angle);
   assign w_next_bit  = w_cross_rst ? 1'b0 : (w_cross_set ? 1'b1 : r_ch_out[r_scan_idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_prev_angle <= '0;
         r_scan_idx   <= '0;
         r_ch_out     <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            r_sh_set[i]  <= '0;
            r_sh_rst[i]  <= '0;
            r_act_set[i] <= '0;
            r_act_rst[i] <= '0;
            r_last[i]    <= '0;
         end
      end else begin
         r_state      <= bus.ena ? S_SCAN : S_IDLE;
         r_prev_angle <= bus.angle;
         for (int i = 0; i < CH_NUM; i++) begin
            r_sh_set[i] <= w_sh_set_nxt[i];
            r_sh_rst[i] <= w_sh_rst_nxt[i];
         end
         if (!w_scan_run) begin
            r_ch_out   <= '0;
            r_scan_idx <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
               r_act_set[i] <= w_sh_set_nxt[i];
               r_act_rst[i] <= w_sh_rst_nxt[i];
               r_last[i]    <= bus.angle;
            end
         end else begin
            r_ch_out[r_scan_idx] <= w_next_bit;
            r_last[r_scan_idx]   <= bus.angle;
            r_scan_idx <= (r_scan_idx == LP_LAST_IDX) ? '0 : r_scan_idx + CH_IDX_W'(1);
            if (w_wrap) begin
               for (int i = 0; i < CH_NUM; i++) begin
                  r_act_set[i] <= w_sh_set_nxt[i];
                  r_act_rst[i] <= w_sh_rst_nxt[i];
               end
            end
         end
      end
   end

   assign bus.ch_out   = r_ch_out;
   assign bus.scan_idx = r_scan_idx;

`ifdef HWAG_SCHED_EVT_IRQ_EN
   logic [CH_NUM-1:0] r_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_evt <= '0;
      end else begin
         r_evt <= '0;
         if (w_scan_run && (w_next_bit != r_ch_out[r_scan_idx]))
            r_evt[r_scan_idx] <= 1'b1;
      end
   end

   assign bus.evt_irq = r_evt;
`else
   assign bus.evt_irq = '0;
`endif
endmodule

// File: tb/tb_hwag_channel_scheduler.sv
// tb/tb_hwag_channel_scheduler.sv - Self-checking bench for hwag_channel_scheduler
module tb_hwag_channel_scheduler;
   localparam int CH  = 8;
   localparam int AW  = 24;
   localparam int IW  = 3;
   localparam int TOP = 359;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   evt0_cnt = 0;
   bit   t1_active = 1'b0;

   always #5 clk = ~clk;

   hwag_sched_if #(.CH_NUM(CH), .ANGLE_W(AW), .CH_IDX_W(IW)) bus ();

   hwag_channel_scheduler #(.CH_NUM(CH), .ANGLE_W(AW), .CH_IDX_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: per-visit behaviour expressed as modular distances.
   int               m_sset [CH];
   int               m_srst [CH];
   int               m_aset [CH];
   int               m_arst [CH];
   int               m_last [CH];
   logic [CH-1:0]    m_out;
   logic [CH-1:0]    m_evt;
   int               m_idx;
   bit               m_run;
   int               m_prev;

   function automatic bit crosses(input int t, input int l, input int a);
      int m  = 1 << AW;
      int dt = (t - l + m) % m;
      int da = (a - l + m) % m;
      return (da != 0) && (dt > 0) && (dt <= da);
   endfunction

   always @(posedge clk or posedge rst) begin
      int a, ch, i;
      bit r, s, nb;
      if (rst) begin
         for (int k = 0; k < CH; k++) begin
            m_sset[k] = 0; m_srst[k] = 0; m_aset[k] = 0; m_arst[k] = 0; m_last[k] = 0;
         end
         m_out = '0; m_evt = '0; m_idx = 0; m_run = 0; m_prev = 0;
      end else begin
         a  = int'(bus.angle);
         ch = int'(bus.cfg_addr[IW:1]);
         if (bus.cfg_we && ch < CH) begin
            if (bus.cfg_addr[0]) m_srst[ch] = int'(bus.cfg_data);
            else                 m_sset[ch] = int'(bus.cfg_data);
         end
         m_evt = '0;
         if (!bus.ena || !m_run) begin
            m_out = '0;
            m_idx = 0;
            for (int k = 0; k < CH; k++) begin
               m_aset[k] = m_sset[k]; m_arst[k] = m_srst[k]; m_last[k] = a;
            end
         end else begin
            i  = m_idx;
            r  = crosses(m_arst[i], m_last[i], a);
            s  = crosses(m_aset[i], m_last[i], a);
            nb = r ? 1'b0 : (s ? 1'b1 : m_out[i]);
`ifdef HWAG_SCHED_EVT_IRQ_EN
            m_evt[i] = (nb != m_out[i]);
`endif
            m_out[i]  = nb;
            m_last[i] = a;
            m_idx     = (m_idx + 1) % CH;
            if (a < m_prev)
               for (int k = 0; k < CH; k++) begin
                  m_aset[k] = m_sset[k]; m_arst[k] = m_srst[k];
               end
         end
         m_run  = bus.ena;
         m_prev = a;
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("ch_out_vs_model",   int'(bus.ch_out),   int'(m_out));
         chk("scan_idx_vs_model", int'(bus.scan_idx), m_idx);
         chk("evt_irq_vs_model",  int'(bus.evt_irq),  int'(m_evt));
         if (t1_active && bus.evt_irq[0]) evt0_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int sel, input int val);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = {ch[IW-1:0], sel[0]};
      bus.cfg_data = val[AW-1:0];
      tick(1);
      bus.cfg_we   = 1'b0;
   endtask

   task automatic sweep(input int from, input int to, input int hold);
      int a = from;
      forever begin
         bus.angle = a[AW-1:0];
         tick(hold);
         if (a == to) break;
         a = (a == TOP) ? 0 : a + 1;
      end
   endtask

   task automatic restart(input int ang);
      bus.ena   = 1'b0;
      bus.angle = ang[AW-1:0];
      tick(1);
   endtask

   initial begin
      int a, pat;
      bus.ena = 1'b0; bus.angle = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      #1;
      chk("reset_ch_out",   int'(bus.ch_out),   0);
      chk("reset_scan_idx", int'(bus.scan_idx), 0);
      chk("reset_evt_irq",  int'(bus.evt_irq),  0);
      tick(2);
      rst = 1'b0;
      tick(1);

      // Slow sweep through set 100 / reset 200 on channel 0.
      wr(0, 0, 100); wr(0, 1, 200);
      t1_active = 1'b1;
      bus.ena = 1'b1;
      sweep(0, 99, 16);   chk("t1_low_before_set", int'(bus.ch_out[0]), 0);
      sweep(100, 100, 8); chk("t1_rise_within_8",  int'(bus.ch_out[0]), 1);
      tick(8);
      sweep(101, 199, 16); chk("t1_high_before_rst", int'(bus.ch_out[0]), 1);
      sweep(200, 200, 8);  chk("t1_fall_within_8",   int'(bus.ch_out[0]), 0);
      tick(8);
      sweep(201, 300, 16);
      t1_active = 1'b0;
`ifdef HWAG_SCHED_EVT_IRQ_EN
      chk("t1_evt_pulses", evt0_cnt, 2);
`else
      chk("t1_evt_pulses", evt0_cnt, 0);
`endif

      // Window spanning the angle wrap.
      restart(300);
      wr(3, 0, 350); wr(3, 1, 10);
      bus.ena = 1'b1;
      sweep(300, 355, 8); chk("t2_high_at_355",    int'(bus.ch_out[3]), 1);
      sweep(356, 5, 8);   chk("t2_high_after_wrap", int'(bus.ch_out[3]), 1);
      sweep(6, 20, 8);    chk("t2_low_after_10",   int'(bus.ch_out[3]), 0);

      // Shadow write is held until the next wrap.
      restart(0);
      wr(1, 0, 50); wr(1, 1, 200);
      bus.ena = 1'b1;
      sweep(0, 60, 8);    chk("t3_rise_at_50",   int'(bus.ch_out[1]), 1);
      sweep(61, 120, 8);
      wr(1, 0, 80);
      sweep(121, 359, 2); chk("t3_fell_at_200",  int'(bus.ch_out[1]), 0);
      sweep(0, 60, 8);    chk("t3_no_old_rise",  int'(bus.ch_out[1]), 0);
      sweep(61, 90, 8);   chk("t3_rise_at_80",   int'(bus.ch_out[1]), 1);

      // Jump over both points, then set == reset.
      restart(90);
      wr(2, 0, 100); wr(2, 1, 200);
      bus.ena = 1'b1;
      tick(16);           chk("t4_low_at_90",   int'(bus.ch_out[2]), 0);
      bus.angle = AW'(210);
      tick(16);           chk("t4_jump_stays_low", int'(bus.ch_out[2]), 0);
      restart(100);
      wr(2, 0, 150); wr(2, 1, 150);
      bus.ena = 1'b1;
      sweep(100, 155, 4); chk("t4_eq_low_155", int'(bus.ch_out[2]), 0);
      sweep(156, 200, 4); chk("t4_eq_low_200", int'(bus.ch_out[2]), 0);

      // ena drop and re-enable mid-window.
      restart(90);
      bus.ena = 1'b1;
      sweep(90, 150, 8);  chk("t5_high_at_150", int'(bus.ch_out[0]), 1);
      bus.ena = 1'b0;
      tick(1);
      chk("t5_drop_ch_out",   int'(bus.ch_out),   0);
      chk("t5_drop_scan_idx", int'(bus.scan_idx), 0);
      tick(3);
      bus.ena = 1'b1;
      tick(24);           chk("t5_no_spurious", int'(bus.ch_out[0]), 0);
      sweep(151, 210, 4); chk("t5_still_low",   int'(bus.ch_out[0]), 0);

      // Randomized angle steps, config writes and ena drops.
      a = 0;
      for (int c = 0; c < 3000; c++) begin
         a = (a + int'($urandom_range(0, 12))) % (TOP + 1);
         bus.angle = a[AW-1:0];
         bus.ena   = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 7) == 0) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = (IW+1)'($urandom_range(0, 2*CH - 1));
            bus.cfg_data = AW'($urandom_range(0, TOP));
         end else begin
            bus.cfg_we   = 1'b0;
         end
         tick(1);
      end
      bus.cfg_we = 1'b0;

      // Async reset with a known output pattern.
      restart(0);
      pat = 'hA5;
      for (int k = 0; k < CH; k++) begin
         if (pat[k]) begin wr(k, 0, 10);   wr(k, 1, 300);  end
         else        begin wr(k, 0, 1000); wr(k, 1, 2000); end
      end
      bus.ena = 1'b1;
      sweep(0, 20, 4);
      chk("t6_pattern_a5", int'(bus.ch_out), 'hA5);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_ch_out",   int'(bus.ch_out),   0);
      chk("t6_async_scan_idx", int'(bus.scan_idx), 0);
      chk("t6_async_evt_irq",  int'(bus.evt_irq),  0);
      tick(2);
      rst = 1'b0;
      sweep(21, 40, 4);
      chk("t6_config_lost", int'(bus.ch_out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
